// File: rtl/compmux_pkg.sv
// compmux_pkg: shared state encoding and default sizing for the comparator mux scanner.
package compmux_pkg;

    localparam int N_CH_DEF    = 16;
    localparam int DWELL_W_DEF = 8;
    localparam int BLANK_DEF   = 2;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DWELL  = 2'd2
    } state_t;

endpackage

// File: rtl/compmux_sync.sv
// compmux_sync: two-flop synchroniser for one asynchronous comparator bit.
module compmux_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    // Metastability guard: first flop may go metastable, second presents a clean level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/compmux_scan.sv
// compmux_scan: routes one of N_CH asynchronous comparator bits through a synchroniser,
// either on a static select or by round-robin scanning, blanking the output for BLANK
// cycles after every select change.
// Optional build macro COMPMUX_ONES_COUNT_EN adds a per-dwell ones counter
// (ones_cnt / ones_last ports).
module compmux_scan
    import compmux_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int SEL_W   = $clog2(N_CH),
    parameter int DWELL_W = DWELL_W_DEF,
    parameter int BLANK   = BLANK_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    adc_comp_in,
    input  logic               enable,
    input  logic               mode,
    input  logic [SEL_W-1:0]   mux_sel,
    input  logic [DWELL_W-1:0] dwell,
    output logic               comp_out,
    output logic               comp_valid,
    output logic [SEL_W-1:0]   cur_sel,
    output logic               scan_wrap
`ifdef COMPMUX_ONES_COUNT_EN
    ,
    output logic [CNT_W-1:0]   ones_cnt,
    output logic [CNT_W-1:0]   ones_last
`endif
);

    localparam int               BLK_W      = $clog2(BLANK);
    localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(N_CH - 1);
    localparam logic [BLK_W-1:0] BLANK_LAST = BLK_W'(BLANK - 1);

    if (N_CH < 2 || N_CH > 64 || BLANK < 2 || CNT_W < 1) begin : g_param_check
        $error("compmux_scan: parameter out of range");
    end

    // Out-of-range static selects map onto the highest real channel.
    function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
        if (int'(s) > N_CH - 1) begin
            return LAST_SEL;
        end
        return s;
    endfunction

    state_t             state;
    logic               mode_q;
    logic [BLK_W-1:0]   blank_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_len;

    logic [SEL_W-1:0]   load_sel;
    logic [SEL_W-1:0]   scan_sel;
    logic [SEL_W-1:0]   sel_nxt;
    logic               mode_chg;
    logic               dwell_done;
    logic               go_settle;
    logic               leave_dwell;
    logic               wrap_nxt;
    logic               sel_bit;

    // Select-change decision: which channel comes next and whether a new blanking window starts.
    always_comb begin
        load_sel    = mode ? '0 : clamp_sel(mux_sel);
        scan_sel    = (cur_sel == LAST_SEL) ? '0 : cur_sel + SEL_W'(1);
        mode_chg    = (state != IDLE) && (mode != mode_q);
        dwell_done  = (dwell_cnt == dwell_len);
        go_settle   = 1'b0;
        sel_nxt     = cur_sel;
        wrap_nxt    = 1'b0;
        if (enable) begin
            if (state == IDLE || mode_chg) begin
                go_settle = 1'b1;
                sel_nxt   = load_sel;
            end else if (state == DWELL) begin
                if (!mode && load_sel != cur_sel) begin
                    go_settle = 1'b1;
                    sel_nxt   = load_sel;
                end else if (mode && dwell_done) begin
                    go_settle = 1'b1;
                    sel_nxt   = scan_sel;
                    // Only a scan step from the last channel counts as a wrap.
                    wrap_nxt  = (cur_sel == LAST_SEL);
                end
            end
        end
        leave_dwell = (state == DWELL) && (!enable || go_settle);
    end

    // Control FSM: IDLE -> SETTLE (BLANK cycles) -> DWELL, with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur_sel    <= '0;
            comp_valid <= 1'b0;
            scan_wrap  <= 1'b0;
            mode_q     <= 1'b0;
            blank_cnt  <= '0;
            dwell_cnt  <= '0;
            dwell_len  <= '0;
        end else begin
            mode_q    <= mode;
            cur_sel   <= sel_nxt;
            scan_wrap <= wrap_nxt;
            if (!enable) begin
                state      <= IDLE;
                comp_valid <= 1'b0;
                blank_cnt  <= '0;
                dwell_cnt  <= '0;
            end else if (go_settle) begin
                state      <= SETTLE;
                comp_valid <= 1'b0;
                blank_cnt  <= '0;
                dwell_cnt  <= '0;
            end else if (state == SETTLE && blank_cnt == BLANK_LAST) begin
                state      <= DWELL;
                comp_valid <= 1'b1;
                dwell_cnt  <= '0;
                // Dwell length is frozen for the whole dwell.
                dwell_len  <= dwell;
            end else if (state == SETTLE) begin
                blank_cnt  <= blank_cnt + BLK_W'(1);
            end else if (state == DWELL && mode) begin
                dwell_cnt  <= dwell_cnt + DWELL_W'(1);
            end
        end
    end

    assign sel_bit = adc_comp_in[cur_sel];

    compmux_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sel_bit),
        .q   (comp_out)
    );

`ifdef COMPMUX_ONES_COUNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
        if (inc && c != '1) begin
            return c + CNT_W'(1);
        end
        return c;
    endfunction

    logic [CNT_W-1:0] ones_nxt;
    assign ones_nxt = sat_inc(ones_cnt, comp_valid & comp_out);

    // Ones tally per dwell; the count including the final dwell cycle is latched on exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            ones_cnt  <= '0;
            ones_last <= '0;
        end else begin
            if (go_settle) begin
                ones_cnt <= '0;
            end else begin
                ones_cnt <= ones_nxt;
            end
            if (leave_dwell) begin
                ones_last <= ones_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_compmux_scan.sv
// tb_compmux_scan: directed scoreboard bench for compmux_scan (static, switch, mode change,
// interrupts, scan timing, clamp and, with COMPMUX_ONES_COUNT_EN, the ones counter).
module tb_compmux_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] adc;
    logic        enable, mode;
    logic [3:0]  mux_sel;
    logic [7:0]  dwell;
    logic        comp_out, comp_valid, scan_wrap;
    logic [3:0]  cur_sel;

    logic [11:0] adc12;
    logic        en12, mode12;
    logic [3:0]  msel12;
    logic [7:0]  dwell12;
    logic        out12, vld12, wrap12;
    logic [3:0]  sel12;

`ifdef COMPMUX_ONES_COUNT_EN
    logic [15:0] ones_cnt, ones_last, ones_cnt12, ones_last12;
    logic [15:0] adc_c2;
    logic        en_c2, mode_c2;
    logic [3:0]  msel_c2;
    logic [7:0]  dwell_c2;
    logic        out_c2, vld_c2, wrap_c2;
    logic [3:0]  sel_c2;
    logic [1:0]  ones_cnt_c2, ones_last_c2;
`endif

    compmux_scan #(.N_CH(16), .DWELL_W(8), .BLANK(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .adc_comp_in(adc), .enable(enable), .mode(mode),
        .mux_sel(mux_sel), .dwell(dwell), .comp_out(comp_out), .comp_valid(comp_valid),
        .cur_sel(cur_sel), .scan_wrap(scan_wrap)
`ifdef COMPMUX_ONES_COUNT_EN
        , .ones_cnt(ones_cnt), .ones_last(ones_last)
`endif
    );

    compmux_scan #(.N_CH(12), .DWELL_W(8), .BLANK(2), .CNT_W(16)) dut12 (
        .clk(clk), .rst(rst), .adc_comp_in(adc12), .enable(en12), .mode(mode12),
        .mux_sel(msel12), .dwell(dwell12), .comp_out(out12), .comp_valid(vld12),
        .cur_sel(sel12), .scan_wrap(wrap12)
`ifdef COMPMUX_ONES_COUNT_EN
        , .ones_cnt(ones_cnt12), .ones_last(ones_last12)
`endif
    );

`ifdef COMPMUX_ONES_COUNT_EN
    compmux_scan #(.N_CH(16), .DWELL_W(8), .BLANK(2), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .adc_comp_in(adc_c2), .enable(en_c2), .mode(mode_c2),
        .mux_sel(msel_c2), .dwell(dwell_c2), .comp_out(out_c2), .comp_valid(vld_c2),
        .cur_sel(sel_c2), .scan_wrap(wrap_c2), .ones_cnt(ones_cnt_c2), .ones_last(ones_last_c2)
    );
`endif

    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    int   chan_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!comp_valid && n < 20) begin
            step();
            n++;
        end
        check(tag, comp_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        b;
        logic [15:0] pat;
        int          lows, runs, run_len, low_len, wraps, last_wrap;
        logic        prev_v;

        rst = 1'b1; adc = '0; enable = 1'b0; mode = 1'b0; mux_sel = '0; dwell = '0;
        adc12 = '0; en12 = 1'b0; mode12 = 1'b0; msel12 = '0; dwell12 = '0;
`ifdef COMPMUX_ONES_COUNT_EN
        adc_c2 = '1; en_c2 = 1'b0; mode_c2 = 1'b1; msel_c2 = '0; dwell_c2 = 8'd7;
`endif
        step(2);
        check("rst_cur_sel", cur_sel, 0);
        check("rst_comp_out", comp_out, 0);
        check("rst_comp_valid", comp_valid, 0);
        check("rst_scan_wrap", scan_wrap, 0);
        rst = 1'b0;
        step();

        // Static select on channel 5
        mode = 1'b0; mux_sel = 4'd5; enable = 1'b1;
        step();
        lows = 0;
        while (!comp_valid && lows < 10) begin
            lows++;
            step();
        end
        check("static_blank", lows, 2);
        check("static_sel", cur_sel, 5);
        for (int i = 0; i < 12; i++) begin
            b = 1'($urandom_range(0, 1));
            adc = 16'($urandom);
            adc[5] = b;
            exp_q.push_back(b);
            step();
            if (exp_q.size() == 2) check("static_out", comp_out, exp_q.pop_front());
        end
        step();
        check("static_out_last", comp_out, exp_q.pop_front());
        check("static_valid", comp_valid, 1);

        // Static switch 5 -> 9
        adc = 16'h0200;
        mux_sel = 4'd9;
        step();
        lows = 0;
        while (!comp_valid && lows < 10) begin
            lows++;
            step();
        end
        check("switch_blank", lows, 2);
        check("switch_sel", cur_sel, 9);
        check("switch_out", comp_out, 1);

        // Mode change reloads the select and re-enters SETTLE
        mode = 1'b1; dwell = 8'd3;
        step();
        check("modechg1_sel", cur_sel, 0);
        check("modechg1_valid", comp_valid, 0);
        mode = 1'b0;
        step();
        check("modechg0_sel", cur_sel, 9);
        check("modechg0_valid", comp_valid, 0);
        wait_valid("modechg0_wait");

        // enable drop in DWELL
        step();
        enable = 1'b0;
        step();
        check("disable_valid", comp_valid, 0);
        check("disable_sel_hold", cur_sel, 9);

        // rst in SETTLE
        enable = 1'b1;
        step();
        check("presrst_valid", comp_valid, 0);
        check("presrst_out", comp_out, 1);
        rst = 1'b1;
        step();
        check("midrst_sel", cur_sel, 0);
        check("midrst_out", comp_out, 0);
        check("midrst_valid", comp_valid, 0);
        check("midrst_wrap", scan_wrap, 0);
        rst = 1'b0; enable = 1'b0;
        step();

        // Auto-scan, dwell=3
        pat = 16'hA5C3;
        adc = pat; mode = 1'b1; dwell = 8'd3; enable = 1'b1;
        for (int k = 0; k < 40; k++) chan_q.push_back(k % 16);
        runs = 0; run_len = 0; low_len = 0; wraps = 0; last_wrap = 0; prev_v = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            step();
            if (scan_wrap) begin
                wraps++;
                check("wrap_sel", cur_sel, 0);
                if (wraps > 1) check("wrap_period", c - last_wrap, 96);
                last_wrap = c;
            end
            if (comp_valid) begin
                if (!prev_v) begin
                    if (chan_q.size() > 0) check("scan_sel", cur_sel, chan_q.pop_front());
                    else check("scan_q_empty", chan_q.size(), 1);
                    if (runs > 0) check("scan_blank", low_len, 2);
                    runs++;
                    run_len = 0;
                end
                run_len++;
                check("scan_out", comp_out, pat[cur_sel]);
            end else begin
                if (prev_v) begin
                    check("scan_dwell", run_len, 4);
                    low_len = 0;
                end
                low_len++;
            end
            prev_v = comp_valid;
        end
        enable = 1'b0;
        step();
        check("wrap_count", wraps, 2);
        check("scan_runs", runs, 33);

        // Clamp on a 12-channel instance
        adc12 = 12'h800; mode12 = 1'b0; msel12 = 4'd14; en12 = 1'b1;
        step(4);
        check("clamp14_sel", sel12, 11);
        check("clamp14_valid", vld12, 1);
        check("clamp14_out", out12, 1);
        msel12 = 4'd3;
        step(4);
        check("clamp3_sel", sel12, 3);
        msel12 = 4'd12;
        step(4);
        check("clamp12_sel", sel12, 11);
        en12 = 1'b0;

`ifdef COMPMUX_ONES_COUNT_EN
        // Ones counter, channel held at 1
        rst = 1'b1;
        step();
        rst = 1'b0;
        adc = '1; mode = 1'b1; dwell = 8'd3; mux_sel = '0; enable = 1'b1;
        begin
            logic seen = 1'b0;
            for (int n = 0; n < 30; n++) begin
                step();
                if (comp_valid) seen = 1'b1;
                if (seen && !comp_valid) break;
            end
            check("ones_exit_seen", seen & ~comp_valid, 1);
        end
        check("ones_last", ones_last, 4);
        check("ones_cnt_clr", ones_cnt, 0);
        enable = 1'b0;

        // Saturation with CNT_W=2, dwell=7
        en_c2 = 1'b1;
        begin
            logic       seen = 1'b0;
            logic [1:0] mx = '0;
            for (int n = 0; n < 40; n++) begin
                step();
                if (ones_cnt_c2 > mx) mx = ones_cnt_c2;
                if (vld_c2) seen = 1'b1;
                if (seen && !vld_c2) break;
            end
            check("sat_exit_seen", seen & ~vld_c2, 1);
            check("sat_cnt_max", mx, 3);
        end
        check("sat_ones_last", ones_last_c2, 3);
        en_c2 = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
